// File: rtl/mps_intr_moderator.sv
// Interrupt moderation between the per-port UART interrupt lines and the single PCI request.
// Coalesces events by count threshold, max-latency timer and post-acknowledge holdoff gap.
module mps_intr_moderator #(
   parameter int unsigned PORT_NUM = 4,
   parameter int unsigned TICK_DIV = 133
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic [PORT_NUM-1:0] irq_src,
   input  logic                cfg_enable,
   input  logic [PORT_NUM-1:0] cfg_mask,
   input  logic [7:0]          cfg_count_thresh,
   input  logic [15:0]         cfg_max_latency,
   input  logic [15:0]         cfg_holdoff,
   input  logic                intr_ack,
   output logic                intr_request,
   output logic [PORT_NUM-1:0] pend_ports,
   output logic [15:0]         intr_count
);

   localparam int unsigned PW    = $clog2(TICK_DIV);
   localparam int unsigned EVT_W = 8;
   localparam int unsigned TMR_W = 16;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCUM   = 2'd1,
      S_ASSERT  = 2'd2,
      S_HOLDOFF = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [EVT_W-1:0]    evt_cnt_q, evt_cnt_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [PORT_NUM-1:0] src_q, src_d;
   logic                req_q, req_d;
   logic [PORT_NUM-1:0] pend_q, pend_d;
   logic [15:0]         cnt_q, cnt_d;

   logic [PORT_NUM-1:0] act_c;
   logic                new_evt_c;
   logic                tick_c;

   // Free-running prescaler; tick marks the wrap and ignores state changes.
   always_comb begin
      tick_c  = (presc_q == PW'(TICK_DIV - 1));
      presc_d = tick_c ? '0 : presc_q + PW'(1);
   end

   always_comb begin
      act_c     = irq_src & cfg_mask;
      src_d     = act_c;
      new_evt_c = |(act_c & ~src_q);
   end

   always_comb begin
      state_d   = state_q;
      evt_cnt_d = evt_cnt_q;
      timer_d   = timer_q;
      req_d     = req_q;
      pend_d    = pend_q;
      cnt_d     = cnt_q;
      if (!cfg_enable) begin
         state_d   = S_IDLE;
         evt_cnt_d = '0;
         timer_d   = '0;
         req_d     = |act_c;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               req_d = 1'b0;
               if (|act_c) begin
                  state_d   = S_ACCUM;
                  evt_cnt_d = EVT_W'(1);
                  timer_d   = cfg_max_latency;
               end
            end
            S_ACCUM: begin
               req_d = 1'b0;
               if (new_evt_c && (evt_cnt_q != {EVT_W{1'b1}})) evt_cnt_d = evt_cnt_q + EVT_W'(1);
               if (tick_c && (timer_q != '0)) timer_d = timer_q - TMR_W'(1);
               if (act_c == '0) begin
                  state_d   = S_IDLE;
                  evt_cnt_d = '0;
               end else if ((evt_cnt_q >= cfg_count_thresh) || (timer_q == '0)) begin
                  state_d = S_ASSERT;
                  req_d   = 1'b1;
                  pend_d  = act_c;
                  cnt_d   = cnt_q + 16'd1;
               end
            end
            S_ASSERT: begin
               req_d = 1'b1;
               if (intr_ack) begin
                  state_d = S_HOLDOFF;
                  req_d   = 1'b0;
                  timer_d = cfg_holdoff;
               end
            end
            S_HOLDOFF: begin
               req_d = 1'b0;
               if (timer_q == '0) state_d = S_IDLE;
               else if (tick_c)   timer_d = timer_q - TMR_W'(1);
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= S_IDLE;
         presc_q   <= '0;
         evt_cnt_q <= '0;
         timer_q   <= '0;
         src_q     <= '0;
         req_q     <= 1'b0;
         pend_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         evt_cnt_q <= evt_cnt_d;
         timer_q   <= timer_d;
         src_q     <= src_d;
         req_q     <= req_d;
         pend_q    <= pend_d;
         cnt_q     <= cnt_d;
      end
   end

   assign intr_request = req_q;
   assign pend_ports   = pend_q;
   assign intr_count   = cnt_q;

endmodule

// File: tb/tb_mps_intr_moderator.sv
// Directed bench for mps_intr_moderator with a fast prescaler (TICK_DIV=4).
module tb_mps_intr_moderator;

   logic        aclk = 1'b0;
   logic        areset;
   logic [3:0]  irq_src;
   logic        cfg_enable;
   logic [3:0]  cfg_mask;
   logic [7:0]  cfg_count_thresh;
   logic [15:0] cfg_max_latency;
   logic [15:0] cfg_holdoff;
   logic        intr_ack;
   logic        intr_request;
   logic [3:0]  pend_ports;
   logic [15:0] intr_count;

   int total = 0;
   int bad   = 0;

   mps_intr_moderator #(.PORT_NUM(4), .TICK_DIV(4)) dut (
      .aclk             (aclk),
      .areset           (areset),
      .irq_src          (irq_src),
      .cfg_enable       (cfg_enable),
      .cfg_mask         (cfg_mask),
      .cfg_count_thresh (cfg_count_thresh),
      .cfg_max_latency  (cfg_max_latency),
      .cfg_holdoff      (cfg_holdoff),
      .intr_ack         (intr_ack),
      .intr_request     (intr_request),
      .pend_ports       (pend_ports),
      .intr_count       (intr_count)
   );

   always #5 aclk = ~aclk;

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      irq_src  = 4'b0000;
      intr_ack = 1'b0;
      areset   = 1'b1;
      step();
      step();
      areset   = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      step();
      step();
      total++;
      if (intr_request !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", intr_request); end
      total++;
      if (pend_ports !== 4'b0000) begin bad++; $display("FAIL reset_pend got=%b exp=0000", pend_ports); end
      total++;
      if (intr_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", intr_count); end
      areset = 1'b0;
   endtask

   task automatic test_bypass();
      do_reset();
      cfg_enable = 1'b0;
      irq_src    = 4'b0100;
      step();
      total++;
      if (intr_request !== 1'b1) begin bad++; $display("FAIL bypass_rise got=%b exp=1", intr_request); end
      intr_ack = 1'b1;
      step();
      intr_ack = 1'b0;
      total++;
      if (intr_request !== 1'b1) begin bad++; $display("FAIL bypass_ack got=%b exp=1", intr_request); end
      irq_src = 4'b0000;
      step();
      total++;
      if (intr_request !== 1'b0) begin bad++; $display("FAIL bypass_fall got=%b exp=0", intr_request); end
      total++;
      if (intr_count !== 16'd0) begin bad++; $display("FAIL bypass_count got=%0d exp=0", intr_count); end
      // clearing enable out of ASSERT drops the request next cycle
      cfg_enable       = 1'b1;
      cfg_count_thresh = 8'd1;
      irq_src          = 4'b0001;
      step();
      step();
      total++;
      if (intr_request !== 1'b1) begin bad++; $display("FAIL bypass_pre_assert got=%b exp=1", intr_request); end
      cfg_enable = 1'b0;
      irq_src    = 4'b0000;
      step();
      total++;
      if (intr_request !== 1'b0) begin bad++; $display("FAIL bypass_disable got=%b exp=0", intr_request); end
      cfg_enable = 1'b1;
   endtask

   task automatic test_threshold();
      cfg_count_thresh = 8'd3;
      cfg_max_latency  = 16'd1000;
      do_reset();
      irq_src = 4'b0011;
      step();
      irq_src = 4'b0010;
      repeat (4) step();
      irq_src = 4'b0011;
      step();
      irq_src = 4'b0010;
      repeat (4) step();
      total++;
      if (intr_request !== 1'b0) begin bad++; $display("FAIL thresh_early got=%b exp=0", intr_request); end
      irq_src = 4'b0001;
      step();
      total++;
      if (intr_request !== 1'b0) begin bad++; $display("FAIL thresh_counted got=%b exp=0", intr_request); end
      step();
      total++;
      if (intr_request !== 1'b1) begin bad++; $display("FAIL thresh_rise got=%b exp=1", intr_request); end
      total++;
      if (pend_ports !== 4'b0001) begin bad++; $display("FAIL thresh_pend got=%b exp=0001", pend_ports); end
      total++;
      if (intr_count !== 16'd1) begin bad++; $display("FAIL thresh_count got=%0d exp=1", intr_count); end
   endtask

   task automatic test_latency();
      int n;
      cfg_count_thresh = 8'd200;
      cfg_max_latency  = 16'd5;
      do_reset();
      irq_src = 4'b0100;
      n = 0;
      while (intr_request !== 1'b1 && n < 30) begin
         step();
         n++;
      end
      total++;
      if (n != 21) begin bad++; $display("FAIL latency_cycles got=%0d exp=21", n); end
      total++;
      if (pend_ports !== 4'b0100) begin bad++; $display("FAIL latency_pend got=%b exp=0100", pend_ports); end
      total++;
      if (intr_count !== 16'd1) begin bad++; $display("FAIL latency_count got=%0d exp=1", intr_count); end
   endtask

   // Runs from the ASSERT state left by test_latency, source still high.
   task automatic test_holdoff();
      int n;
      cfg_count_thresh = 8'd1;
      cfg_holdoff      = 16'd10;
      intr_ack = 1'b1;
      step();
      intr_ack = 1'b0;
      total++;
      if (intr_request !== 1'b0) begin bad++; $display("FAIL holdoff_drop got=%b exp=0", intr_request); end
      n = 1;
      while (intr_request !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      total++;
      if (n < 40 || n > 44) begin bad++; $display("FAIL holdoff_gap got=%0d exp=40..44", n); end
      total++;
      if (intr_count !== 16'd2) begin bad++; $display("FAIL holdoff_count got=%0d exp=2", intr_count); end
   endtask

   task automatic test_mask_drop();
      cfg_count_thresh = 8'd1;
      do_reset();
      cfg_mask = 4'b1110;
      irq_src  = 4'b0001;
      repeat (10) step();
      total++;
      if (intr_request !== 1'b0) begin bad++; $display("FAIL mask_req got=%b exp=0", intr_request); end
      total++;
      if (intr_count !== 16'd0) begin bad++; $display("FAIL mask_count got=%0d exp=0", intr_count); end
      cfg_mask         = 4'b1111;
      cfg_count_thresh = 8'd5;
      cfg_max_latency  = 16'd1000;
      irq_src          = 4'b0010;
      step();
      step();
      total++;
      if (dut.evt_cnt_q !== 8'd1) begin bad++; $display("FAIL drop_accum_evt got=%0d exp=1", dut.evt_cnt_q); end
      irq_src = 4'b0000;
      step();
      total++;
      if (dut.evt_cnt_q !== 8'd0) begin bad++; $display("FAIL drop_evt got=%0d exp=0", dut.evt_cnt_q); end
      total++;
      if (intr_request !== 1'b0) begin bad++; $display("FAIL drop_req got=%b exp=0", intr_request); end
   endtask

   task automatic test_reset_mid_assert();
      cfg_count_thresh = 8'd1;
      do_reset();
      irq_src = 4'b0001;
      step();
      step();
      total++;
      if (intr_request !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b exp=1", intr_request); end
      areset = 1'b1;
      step();
      total++;
      if (intr_request !== 1'b0) begin bad++; $display("FAIL rst_mid_req got=%b exp=0", intr_request); end
      total++;
      if (pend_ports !== 4'b0000) begin bad++; $display("FAIL rst_mid_pend got=%b exp=0000", pend_ports); end
      total++;
      if (intr_count !== 16'd0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", intr_count); end
      areset  = 1'b0;
      irq_src = 4'b0000;
   endtask

   task automatic test_stray_ack();
      cfg_count_thresh = 8'd1;
      do_reset();
      intr_ack = 1'b1;
      step();
      intr_ack = 1'b0;
      step();
      total++;
      if (intr_request !== 1'b0) begin bad++; $display("FAIL stray_idle_req got=%b exp=0", intr_request); end
      irq_src = 4'b1000;
      step();
      intr_ack = 1'b1;
      step();
      intr_ack = 1'b0;
      total++;
      if (intr_request !== 1'b1) begin bad++; $display("FAIL stray_entry_req got=%b exp=1", intr_request); end
      step();
      total++;
      if (intr_request !== 1'b1) begin bad++; $display("FAIL stray_hold_req got=%b exp=1", intr_request); end
      total++;
      if (pend_ports !== 4'b1000) begin bad++; $display("FAIL stray_pend got=%b exp=1000", pend_ports); end
      total++;
      if (intr_count !== 16'd1) begin bad++; $display("FAIL stray_count got=%0d exp=1", intr_count); end
   endtask

   initial begin
      areset           = 1'b1;
      irq_src          = 4'b0000;
      cfg_enable       = 1'b1;
      cfg_mask         = 4'b1111;
      cfg_count_thresh = 8'd1;
      cfg_max_latency  = 16'd1000;
      cfg_holdoff      = 16'd0;
      intr_ack         = 1'b0;
      test_reset();
      test_bypass();
      test_threshold();
      test_latency();
      test_holdoff();
      test_mask_drop();
      test_reset_mid_assert();
      test_stray_ack();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mps_intr_moderator.md
Name: mps_intr_moderator

Overview:
- Interrupt moderation controller between the per-port UART interrupt lines of the multi-port serial core and the single PCI interrupt request.
- Coalesces UART events using an event-count threshold, a maximum-latency timer and a minimum holdoff gap after each host acknowledge, so that interrupt rate stays bounded under heavy traffic.
- Runs in the aclk (UART clock) domain. Its intr_request output feeds the existing two-flop synchroniser into the PCI core.

Parameters:
- PORT_NUM, 4, number of UART interrupt sources.
- TICK_DIV, 133, aclk cycles per timer tick (about 1 us at 7.5 ns). Legal range 2..65535.

Ports:
- aclk  input  1  clock.
- areset  input  1  synchronous, active-high reset.
- irq_src  input  PORT_NUM  per-port level interrupt from the UART channels.
- cfg_enable  input  1  0 = bypass moderation, 1 = moderate.
- cfg_mask  input  PORT_NUM  1 = source enabled.
- cfg_count_thresh  input  8  number of events that forces an interrupt.
- cfg_max_latency  input  16  ticks from first event to forced interrupt.
- cfg_holdoff  input  16  ticks of minimum gap after acknowledge.
- intr_ack  input  1  single-cycle host acknowledge (register write strobe).
- intr_request  output  1  interrupt to the PCI core, registered.
- pend_ports  output  PORT_NUM  masked sources captured when entering ASSERT.
- intr_count  output  16  count of ASSERT entries, wraps modulo 2^16.

Behaviour:
- Reset values: all outputs 0. State IDLE. Prescaler, evt_cnt, timer and src_q all 0.
- Prescaler: free-running counter 0..TICK_DIV-1. The tick pulse is high for one cycle on wrap. It is not restarted by state changes.
- Source handling:
  - act = irq_src & cfg_mask.
  - src_q = registered act.
  - edge = act & ~src_q.
  - new_evt = |edge, counted as one event per cycle regardless of how many bits are set.
- Bypass (cfg_enable=0):
  - State forced to IDLE; counters cleared.
  - intr_request <= |act, giving 1 cycle latency.
  - intr_ack has no effect; intr_count does not increment.
  - Clearing cfg_enable from any state takes effect on the next cycle.
- Moderated FSM (cfg_enable=1):
  - IDLE:
    - If |act, go to ACCUM with evt_cnt <= 1 and timer <= cfg_max_latency.
    - intr_request = 0.
  - ACCUM:
    - evt_cnt increments on new_evt and saturates at 255.
    - timer decrements on tick and saturates at 0.
    - If act == 0, go to IDLE and clear evt_cnt.
    - Else if evt_cnt >= cfg_count_thresh or timer == 0, go to ASSERT. Threshold 0 or 1 therefore asserts on the cycle after ACCUM entry; latency 0 does the same.
  - ASSERT:
    - On entry: intr_request <= 1, pend_ports <= act, intr_count += 1.
    - Stays in ASSERT until intr_ack. The interrupt stays asserted even if the sources drop.
    - On intr_ack: go to HOLDOFF, intr_request <= 0, timer <= cfg_holdoff.
  - HOLDOFF:
    - intr_request = 0.
    - timer decrements on tick.
    - When timer == 0, go to IDLE. With cfg_holdoff=0 this is the next cycle.
    - Events arriving during HOLDOFF are not counted. Sources still high are picked up from IDLE.
- Timing: if irq_src rises at cycle N with threshold 1, the state is ACCUM at N+1 and intr_request = 1 at N+2.
- intr_ack outside ASSERT is ignored, including an ack in the same cycle ASSERT is entered.
- Configuration inputs are sampled when used (timer load, compare). Changing them mid-state affects the next compare or load only.
- areset mid-operation returns everything to reset values on the next edge; intr_request drops.

Test Plan:
- Bypass: cfg_enable=0, irq_src=4'b0100 -> intr_request=1 one cycle later, drops one cycle after irq_src=0; intr_count stays 0.
- Threshold: TICK_DIV=4, thresh=3, latency=1000, three rising edges on port0 spaced 5 cycles apart -> intr_request rises 1 cycle after the third edge is counted; pend_ports=4'b0001; intr_count=1.
- Latency: thresh=200, latency=5, single edge on port2 held high -> intr_request rises within 5*4+3 cycles of the edge; pend_ports=4'b0100.
- Holdoff: assert, then pulse intr_ack with holdoff=10 and the source still high -> intr_request low for at least 40 cycles, then reasserts via IDLE->ACCUM; intr_count=2.
- Masking and drop: cfg_mask=4'b1110, irq_src=4'b0001 -> no interrupt. In ACCUM, drop all sources before threshold -> returns to IDLE with evt_cnt=0.
- Reset mid-ASSERT and stray ack: areset while intr_request=1 -> all outputs 0 next cycle. intr_ack pulsed in IDLE -> no state change.
